// File: rtl/ahb_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module : ahb_uart_bridge
// AHB-Lite register window onto a byte UART: RX FIFO, TX holding register.
// Rev    : 1.0
// ============================================================================
module ahb_uart_bridge #(
  parameter int RX_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELx,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        irq
);

  localparam int               PTR_W       = $clog2(RX_DEPTH);
  localparam int               CNT_W       = 5;
  localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(RX_DEPTH);
  localparam logic [1:0]       C_REG_DATA  = 2'd0;
  localparam logic [1:0]       C_REG_STAT  = 2'd1;
  localparam logic [1:0]       C_REG_CTRL  = 2'd2;

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_GUARD = 2'd2} tx_state_e;

  logic             r_dp_valid, r_dp_write;
  logic [1:0]       r_dp_addr;
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_rx_count;
  logic             r_overrun, r_rx_irq_en, r_irq;
  logic [7:0]       r_tx_hold, r_tx_data;
  logic             r_tx_hold_full;
  tx_state_e        r_tx_state, w_tx_state_nxt;
  logic             w_drain, w_addr_valid, w_wr_data, w_wr_done, w_rd_phase;
  logic             w_rx_not_empty, w_rx_full, w_pop, w_push, w_overflow, w_tx_active;
  logic [31:0]      w_rdata;
  logic             w_unused_ok;

  assign w_unused_ok = ^{HSIZE, HBURST, HPROT, HMASTLOCK, HTRANS[0],
                         HADDR[31:4], HADDR[1:0], HWDATA[31:8]};

  assign w_addr_valid   = HSELx & HREADY & HTRANS[1];
  assign w_wr_data      = r_dp_valid & r_dp_write & (r_dp_addr == C_REG_DATA);
  // Only a DATA write against an occupied holding register ever waits.
  assign HREADYOUT      = ~(w_wr_data & r_tx_hold_full);
  assign HRESP          = 1'b0;
  assign w_wr_done      = r_dp_valid & r_dp_write & HREADYOUT;
  assign w_rd_phase     = r_dp_valid & ~r_dp_write;
  assign w_rx_not_empty = (r_rx_count != '0);
  assign w_rx_full      = (r_rx_count == C_DEPTH);
  assign w_pop          = w_rd_phase & (r_dp_addr == C_REG_DATA) & w_rx_not_empty;
  assign w_push         = rx_ready & (~w_rx_full | w_pop);
  assign w_overflow     = rx_ready & w_rx_full & ~w_pop;
  assign w_tx_active    = tx_busy | (r_tx_state != TX_IDLE);
  assign tx_data        = r_tx_data;
  assign irq            = r_irq;
  assign HRDATA         = w_rdata;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= 2'd0;
    end else if (HREADY) begin
      r_dp_valid <= w_addr_valid;
      r_dp_write <= HWRITE;
      r_dp_addr  <= HADDR[3:2];
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_push) r_rx_mem[r_wr_ptr] <= rx_data;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rx_count  <= '0;
      r_overrun   <= 1'b0;
      r_rx_irq_en <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_rx_count <= r_rx_count + CNT_W'(1);
        2'b01:   r_rx_count <= r_rx_count - CNT_W'(1);
        default: r_rx_count <= r_rx_count;
      endcase
      if (w_overflow)
        r_overrun <= 1'b1;
      else if (w_wr_done && r_dp_addr == C_REG_STAT && HWDATA[3])
        r_overrun <= 1'b0;
      if (w_wr_done && r_dp_addr == C_REG_CTRL)
        r_rx_irq_en <= HWDATA[0];
      r_irq <= r_rx_irq_en & w_rx_not_empty;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_tx_state     <= TX_IDLE;
      r_tx_hold      <= 8'h00;
      r_tx_hold_full <= 1'b0;
      r_tx_data      <= 8'h00;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (w_drain) begin
        r_tx_data      <= r_tx_hold;
        r_tx_hold_full <= 1'b0;
      end else if (w_wr_done && r_dp_addr == C_REG_DATA) begin
        r_tx_hold      <= HWDATA[7:0];
        r_tx_hold_full <= 1'b1;
      end
    end
  end

  // GUARD gives the UART a cycle to raise tx_busy before the next drain.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_drain        = 1'b0;
    tx_start       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (r_tx_hold_full && !tx_busy) begin
          w_tx_state_nxt = TX_START;
          w_drain        = 1'b1;
        end
      end
      TX_START: begin
        tx_start       = 1'b1;
        w_tx_state_nxt = TX_GUARD;
      end
      TX_GUARD: w_tx_state_nxt = TX_IDLE;
      default:  w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = 32'h0;
    if (w_rd_phase) begin
      case (r_dp_addr)
        C_REG_DATA: w_rdata = w_rx_not_empty ? {24'h0, r_rx_mem[r_rd_ptr]} : 32'h0;
        C_REG_STAT: w_rdata = {23'h0, r_rx_count, r_overrun, w_tx_active,
                               r_tx_hold_full, w_rx_not_empty};
        C_REG_CTRL: w_rdata = {31'h0, r_rx_irq_en};
        default:    w_rdata = 32'h0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_ahb_uart_bridge
// Directed self-checking bench for ahb_uart_bridge.
// Rev    : 1.0
// ============================================================================
module tb_ahb_uart_bridge;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        HSELx = 1'b0, HWRITE = 1'b0, HMASTLOCK = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [2:0]  HSIZE = 3'b010, HBURST = 3'b000;
  logic [3:0]  HPROT = 4'b0011;
  logic [1:0]  HTRANS = 2'b00;
  logic        HREADY, HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic [7:0]  tx_data, rx_data = 8'h00;
  logic        tx_start, tx_busy = 1'b0, rx_ready = 1'b0, irq;

  int          checks = 0, errors = 0;
  logic [7:0]  tx_log[$];

  assign HREADY = HREADYOUT;

  ahb_uart_bridge #(.RX_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(HSELx), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_ready(rx_ready), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) if (HRESETn && tx_start) tx_log.push_back(tx_data);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data, output int stalls);
    HSELx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    tick();
    HSELx = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    stalls = 0;
    while (HREADYOUT !== 1'b1 && stalls < 50) begin
      tick();
      stalls++;
    end
    tick();
  endtask

  task automatic ahb_read(input logic [31:0] addr, input logic push, input logic [7:0] pv,
                          output logic [31:0] data);
    HSELx = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    tick();
    HSELx = 1'b0; HTRANS = 2'b00;
    if (push) begin rx_ready = 1'b1; rx_data = pv; end
    data = HRDATA;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] v);
    rx_data = v; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    int          s;
    logic [31:0] d;

    // Reset values
    repeat (3) tick();
    check("rst_hreadyout", HREADYOUT, 1);
    check("rst_hresp", HRESP, 0);
    check("rst_hrdata", HRDATA, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_irq", irq, 0);
    HRESETn = 1'b1;
    tick();
    ahb_read(32'h4, 0, 8'h00, d); check("rst_status", d, 32'h0);
    ahb_read(32'h8, 0, 8'h00, d); check("rst_ctrl", d, 32'h0);

    // Single byte transmit
    ahb_write(32'h0, 32'h41, s); check("t1_stall", s, 0);
    check("t1_start_early", tx_start, 0);
    tick();
    check("t1_start", tx_start, 1);
    check("t1_tx_data", tx_data, 32'h41);
    tick();
    check("t1_start_len", tx_start, 0);
    ahb_read(32'h4, 0, 8'h00, d); check("t1_status", d, 32'h0);
    check("t1_log_n", tx_log.size(), 1);
    if (tx_log.size() > 0) check("t1_log0", tx_log[0], 32'h41);
    tx_log.delete();

    // Reserved register
    ahb_write(32'hC, 32'hFFFF_FFFF, s); check("rsv_stall", s, 0);
    ahb_read(32'hC, 0, 8'h00, d); check("rsv_read", d, 32'h0);
    ahb_read(32'h8, 0, 8'h00, d); check("rsv_ctrl", d, 32'h0);

    // Back-pressure while the UART is busy
    tx_busy = 1'b1;
    ahb_write(32'h0, 32'h11, s); check("t2_stall1", s, 0);
    ahb_read(32'h4, 0, 8'h00, d); check("t2_status", d, 32'h6);
    fork
      ahb_write(32'h0, 32'h22, s);
      begin repeat (4) @(posedge HCLK); #1; tx_busy = 1'b0; end
    join
    check("t2_stall2", s, 4);
    repeat (6) tick();
    check("t2_log_n", tx_log.size(), 2);
    if (tx_log.size() > 1) begin
      check("t2_log0", tx_log[0], 32'h11);
      check("t2_log1", tx_log[1], 32'h22);
    end

    // RX fill past capacity
    for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
    ahb_read(32'h4, 0, 8'h00, d); check("t3_status_full", d, 32'h49);
    for (int i = 0; i < 4; i++) begin
      ahb_read(32'h0, 0, 8'h00, d); check("t3_data", d, 32'hA0 + 32'(i));
    end
    ahb_read(32'h0, 0, 8'h00, d); check("t3_data_empty", d, 32'h0);
    ahb_read(32'h4, 0, 8'h00, d); check("t3_status_ovr", d, 32'h08);
    ahb_write(32'h4, 32'h8, s); check("t3_clr_stall", s, 0);
    ahb_read(32'h4, 0, 8'h00, d); check("t3_status_clr", d, 32'h0);

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 4; i++) push_byte(8'hB0 + 8'(i));
    ahb_read(32'h4, 0, 8'h00, d); check("t4_status_full", d, 32'h41);
    ahb_read(32'h0, 1, 8'h55, d); check("t4_pop_push", d, 32'hB0);
    ahb_read(32'h4, 0, 8'h00, d); check("t4_status_same", d, 32'h41);
    for (int i = 1; i < 4; i++) begin
      ahb_read(32'h0, 0, 8'h00, d); check("t4_data", d, 32'hB0 + 32'(i));
    end
    ahb_read(32'h0, 0, 8'h00, d); check("t4_data_last", d, 32'h55);
    ahb_read(32'h4, 0, 8'h00, d); check("t4_status_end", d, 32'h0);

    // Interrupt
    ahb_write(32'h8, 32'h1, s); check("t5_ctrl_stall", s, 0);
    ahb_read(32'h8, 0, 8'h00, d); check("t5_ctrl", d, 32'h1);
    check("t5_irq_idle", irq, 0);
    push_byte(8'hC3);
    check("t5_irq_lag", irq, 0);
    tick();
    check("t5_irq_set", irq, 1);
    ahb_read(32'h0, 0, 8'h00, d); check("t5_data", d, 32'hC3);
    check("t5_irq_hold", irq, 1);
    tick();
    check("t5_irq_clr", irq, 0);

    // Reset during START
    for (int i = 0; i < 5; i++) push_byte(8'hD0 + 8'(i));
    tick();
    check("t6_irq_pre", irq, 1);
    ahb_write(32'h0, 32'h77, s); check("t6_stall", s, 0);
    tick();
    check("t6_start", tx_start, 1);
    #2 HRESETn = 1'b0;
    #1;
    check("t6_rst_start", tx_start, 0);
    check("t6_rst_irq", irq, 0);
    check("t6_rst_hready", HREADYOUT, 1);
    check("t6_rst_txdata", tx_data, 0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    tick();
    ahb_read(32'h4, 0, 8'h00, d); check("t6_status", d, 32'h0);
    ahb_read(32'h8, 0, 8'h00, d); check("t6_ctrl", d, 32'h0);
    check("t6_hrdata_idle", HRDATA, 0);
    check("t6_hresp", HRESP, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_uart_bridge.md
AHB_UART_BRIDGE -- requirements
Module: ahb_uart_bridge

Interface
REQ-001 The block SHALL have parameter RX_DEPTH, default 4 (power of two, 2..16), giving the RX FIFO depth in bytes.
REQ-002 The block SHALL have port HCLK, input, 1, the single clock.
REQ-003 The block SHALL have port HRESETn, input, 1, reset; asynchronous assertion, active-low.
REQ-004 The block SHALL have AHB-Lite responder inputs: HSELx 1, HADDR 32, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4, HTRANS 2, HMASTLOCK 1, HREADY 1, HWDATA 32.
REQ-005 The block SHALL have AHB-Lite responder outputs: HREADYOUT 1, HRESP 1, HRDATA 32.
REQ-006 The block SHALL have UART-side ports: tx_data output 8, tx_start output 1, tx_busy input 1, rx_data input 8, rx_ready input 1 (one-cycle strobe).
REQ-007 The block SHALL have port irq, output, 1, RX interrupt.

Function
REQ-008 The block SHALL register an address phase when HSELx & HREADY & HTRANS[1]; the data phase is the following cycle(s); HSIZE, HBURST, HPROT and HMASTLOCK are ignored.
REQ-009 The block SHALL decode HADDR[3:2]: 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved (reads 0, writes ignored).
REQ-010 The block SHALL drive HRESP = 0 (OKAY) at all times.
REQ-011 The block SHALL drive HRDATA only in a read data phase; HRDATA = 0 otherwise.
REQ-012 A DATA read SHALL return {24'b0, RX FIFO head}, and SHALL pop one entry at the end of the data phase; a DATA read when the FIFO is empty SHALL return 0 and not pop.
REQ-013 A STATUS read SHALL return bit0 rx_not_empty, bit1 tx_hold_full, bit2 tx_active (tx_busy | TX FSM not IDLE), bit3 overrun, bits[8:4] rx_count, and all other bits 0.
REQ-014 A STATUS write with HWDATA[3] = 1 SHALL clear overrun; all other STATUS bits are read-only.
REQ-015 CTRL bit0 SHALL be rx_irq_en, read/write; all other CTRL bits SHALL read 0.
REQ-016 irq SHALL be registered: irq = rx_irq_en & rx_not_empty, updated one cycle after either term changes.
REQ-017 The RX FIFO SHALL push rx_data on each rx_ready cycle.
REQ-018 Push when full without a same-cycle pop SHALL drop the byte and set overrun (sticky).
REQ-019 A same-cycle push and pop SHALL both succeed, leave rx_count unchanged, and never set overrun.
REQ-020 FIFO pointers SHALL wrap modulo RX_DEPTH.
REQ-021 A DATA write SHALL load HWDATA[7:0] into a one-entry TX holding register and set tx_hold_full.
REQ-022 If tx_hold_full = 1 during a DATA write data phase, HREADYOUT SHALL be 0 until the holding register drains; the write then completes with HREADYOUT = 1.
REQ-023 HREADYOUT SHALL be 1 in all other cases.
REQ-024 The TX FSM SHALL have three states: IDLE, START, GUARD.
REQ-025 IDLE -> START when tx_hold_full & !tx_busy; on this transition tx_data is loaded and tx_hold_full is cleared.
REQ-026 In START, tx_start SHALL be 1 for exactly one cycle; the FSM then moves to GUARD.
REQ-027 GUARD SHALL last one cycle, covering tx_busy assertion lag, and then return to IDLE.
REQ-028 Minimum byte-to-byte spacing SHALL be 3 cycles plus the tx_busy duration.
REQ-029 A DATA write data phase that coincides with the IDLE -> START drain SHALL complete in the next cycle, loading the new byte into the freed holding register.

Reset
REQ-030 On HRESETn low (asynchronous), the block SHALL reset: HREADYOUT = 1, HRDATA = 0, HRESP = 0, tx_start = 0, tx_data = 0, irq = 0, FIFO empty, rx_count = 0, overrun = 0, tx_hold_full = 0, rx_irq_en = 0, TX FSM = IDLE, pending data phase discarded.
REQ-031 Reset asserted mid-transfer or mid-START SHALL abort the transfer and deassert tx_start immediately; deassertion SHALL be synchronous to HCLK.

Verification
REQ-032 Write 0x41 to DATA with tx_busy = 0 -> tx_start pulses 1 cycle with tx_data = 0x41, two cycles after the write data phase; STATUS bit1 then reads 0.
REQ-033 Hold tx_busy = 1, write 0x11 then 0x22 -> the second write stalls (HREADYOUT = 0) until tx_busy falls; bytes are emitted in order 0x11, 0x22.
REQ-034 Strobe rx_ready with 0xA0..0xA4 at RX_DEPTH = 4 -> STATUS reads count 4, overrun = 1; DATA reads return 0xA0..0xA3, then 0.
REQ-035 With the FIFO full, a DATA read coinciding with rx_ready 0x55 -> overrun stays 0, count stays 4, and 0x55 is read last.
REQ-036 Set CTRL = 1, push one byte -> irq = 1 one cycle later; a DATA read drops irq to 0; STATUS write 0x8 clears overrun.
REQ-037 Assert HRESETn = 0 during a START cycle -> tx_start = 0 at once; all STATUS bits read 0 after release.
